// File: rtl/simplebus_req_queue_if.sv
// Core-side request/response port of the simplebus queued leader.
// The core drives requests through the master modport and the queue serves them through the slave modport.
interface simplebus_req_queue_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [23:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_write, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_write, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/simplebus_req_queue.sv
// FIFO-buffered leader for the simplebus shared bus: it issues queued requests in order
// as three address bytes plus one data phase, and returns one response per request.
module simplebus_req_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clock,
    input  logic                 resetN,
    simplebus_req_queue_if.slave req,
    output logic                 bus_start,
    output logic                 bus_read,
    output logic [7:0]           bus_address,
    inout  wire  [7:0]           bus_data,
    inout  wire                  bus_dataValid
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int ENT_W  = 33;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_UP,
        ADDR_MID,
        ADDR_LO,
        WR_DATA,
        RD_WAIT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ENT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [ENT_W-1:0]  w_head;

    logic              r_cur_write;
    logic [23:0]       r_cur_addr;
    logic [7:0]        r_cur_wdata;

    logic [WAIT_W-1:0] r_wait;
    logic              w_dv;
    logic              w_expire;
    logic              w_done_wr;
    logic              w_done_rd;
    logic              w_done_to;

    logic              w_addr_en;
    logic [7:0]        w_addr_byte;
    logic              w_data_en;

    logic              r_rsp_valid;
    logic              r_rsp_write;
    logic [7:0]        r_rsp_data;
    logic              r_rsp_err;

    // ---- request FIFO ----
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_push  = req.req_valid && !w_full;
    assign w_pop   = (r_state == IDLE) && !w_empty;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= {req.req_write, req.req_addr, req.req_wdata};
    end

    // ---- current transaction, loaded on the IDLE->ADDR_UP edge ----
    always_ff @(posedge clock) begin
        if (w_pop) begin
            r_cur_write <= w_head[32];
            r_cur_addr  <= w_head[31:8];
            r_cur_wdata <= w_head[7:0];
        end
    end

    // ---- bus sequencer ----
    // A floating or unknown dataValid must never count as a handshake.
    assign w_dv     = (bus_dataValid === 1'b1);
    assign w_expire = (r_wait == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == RD_WAIT) r_wait <= r_wait + 1'b1;
            else                    r_wait <= '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_wr   = 1'b0;
        w_done_rd   = 1'b0;
        w_done_to   = 1'b0;
        bus_start   = 1'b0;
        bus_read    = 1'b0;
        w_addr_en   = 1'b0;
        w_addr_byte = 8'h00;
        w_data_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) w_state_nxt = ADDR_UP;
            end
            ADDR_UP: begin
                bus_start   = 1'b1;
                w_addr_en   = 1'b1;
                w_addr_byte = r_cur_addr[23:16];
                w_state_nxt = ADDR_MID;
            end
            ADDR_MID: begin
                w_addr_en   = 1'b1;
                w_addr_byte = r_cur_addr[15:8];
                w_state_nxt = ADDR_LO;
            end
            ADDR_LO: begin
                w_addr_en   = 1'b1;
                w_addr_byte = r_cur_addr[7:0];
                bus_read    = !r_cur_write;
                w_state_nxt = r_cur_write ? WR_DATA : RD_WAIT;
            end
            WR_DATA: begin
                w_data_en   = 1'b1;
                w_done_wr   = 1'b1;
                w_state_nxt = IDLE;
            end
            RD_WAIT: begin
                // Data arriving on the expiry cycle still completes the read.
                if (w_dv) begin
                    w_done_rd   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_expire) begin
                    w_done_to   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus_address   = w_addr_en ? w_addr_byte : 8'hzz;
    assign bus_data      = w_data_en ? r_cur_wdata : 8'hzz;
    assign bus_dataValid = w_data_en ? 1'b1 : 1'bz;

    // ---- registered response ----
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_done_wr || w_done_rd || w_done_to;
            if (w_done_wr) begin
                r_rsp_write <= 1'b1;
                r_rsp_data  <= 8'h00;
                r_rsp_err   <= 1'b0;
            end else if (w_done_rd) begin
                r_rsp_write <= 1'b0;
                r_rsp_data  <= bus_data;
                r_rsp_err   <= 1'b0;
            end else if (w_done_to) begin
                r_rsp_write <= 1'b0;
                r_rsp_data  <= 8'hFF;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    assign req.req_ready = !w_full;
    assign req.rsp_valid = r_rsp_valid;
    assign req.rsp_write = r_rsp_write;
    assign req.rsp_data  = r_rsp_data;
    assign req.rsp_err   = r_rsp_err;
    assign req.busy      = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_simplebus_req_queue.sv
// Bench for simplebus_req_queue: a follower-0 memory on the bus and an in-order
// response scoreboard fed by a request-level reference model.
module tb_simplebus_req_queue;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    typedef struct {
        bit          w;
        logic [23:0] a;
        logic [7:0]  d;
    } req_t;

    typedef struct {
        bit         w;
        logic [7:0] d;
        bit         e;
    } rsp_t;

    logic clock  = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    simplebus_req_queue_if rq();

    wire       bus_start;
    wire       bus_read;
    wire [7:0] bus_address;
    wire [7:0] bus_data;
    wire       bus_dataValid;

    logic       fol_drv  = 1'b0;
    logic [7:0] fol_data = 8'h00;
    assign bus_data      = fol_drv ? fol_data : 8'hzz;
    assign bus_dataValid = fol_drv ? 1'b1 : 1'bz;

    simplebus_req_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock         (clock),
        .resetN        (resetN),
        .req           (rq),
        .bus_start     (bus_start),
        .bus_read      (bus_read),
        .bus_address   (bus_address),
        .bus_data      (bus_data),
        .bus_dataValid (bus_dataValid)
    );

    int   n_checks = 0;
    int   n_errs   = 0;
    int   cyc      = 0;
    int   push_cyc = 0;
    int   fol_fixed_d = -1;
    int   rsp_cyc_q[$];
    req_t iss_q[$];
    rsp_t exp_q[$];
    logic [7:0] ref_mem [65536];
    logic [7:0] fol_mem [65536];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Request-level reference: each request maps to its response by the bus rules alone.
    function automatic rsp_t model(input bit w, input logic [23:0] a, input logic [7:0] d);
        rsp_t e;
        if (w) begin
            if (a[23:16] == 8'h00) ref_mem[a[15:0]] = d;
            e.w = 1'b1; e.d = 8'h00; e.e = 1'b0;
        end else if (a[23:16] == 8'h00) begin
            e.w = 1'b0; e.d = ref_mem[a[15:0]]; e.e = 1'b0;
        end else begin
            e.w = 1'b0; e.d = 8'hFF; e.e = 1'b1;
        end
        return e;
    endfunction

    // Response monitor.
    logic prev_rsp = 1'b0;
    always @(negedge clock) begin
        if (resetN && rq.rsp_valid === 1'b1) begin
            rsp_cyc_q.push_back(cyc);
            check_val("rsp_pulse", prev_rsp, 0);
            if (exp_q.size() == 0) begin
                check_val("rsp_unexpected", exp_q.size(), 1);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check_val("rsp_write", rq.rsp_write, e.w);
                check_val("rsp_data", rq.rsp_data, e.d);
                check_val("rsp_err", rq.rsp_err, e.e);
            end
        end
        prev_rsp = resetN && (rq.rsp_valid === 1'b1);
    end

    // Follower 0 memory; any other follower number is absent from the bus.
    int         fph = 0;
    int         fcnt = 0;
    logic [7:0] fhi = 8'h00, fmid = 8'h00, flo = 8'h00;
    logic [7:0] fwd = 8'h00;
    always @(negedge clock) begin
        if (!resetN) begin
            fph     = 0;
            fol_drv = 1'b0;
        end else begin
            case (fph)
                0: if (bus_start === 1'b1) begin
                    fhi = bus_address;
                    fph = 1;
                end
                1: begin
                    check_val("start_one_cycle", bus_start, 0);
                    fmid = bus_address;
                    fph  = 2;
                end
                2: begin
                    flo = bus_address;
                    if (iss_q.size() == 0) begin
                        check_val("bus_unexpected", iss_q.size(), 1);
                    end else begin
                        req_t r;
                        r   = iss_q.pop_front();
                        fwd = r.d;
                        check_val("bus_addr", {fhi, fmid, flo}, r.a);
                        check_val("bus_read", bus_read, !r.w);
                    end
                    if (bus_read === 1'b1) begin
                        fph  = (fhi == 8'h00) ? 4 : 0;
                        fcnt = (fol_fixed_d >= 0) ? fol_fixed_d : int'($urandom_range(0, 7));
                    end else begin
                        fph = 3;
                    end
                end
                3: begin
                    check_val("wr_dataValid", bus_dataValid, 1);
                    check_val("wr_data", bus_data, fwd);
                    if (fhi == 8'h00) fol_mem[{fmid, flo}] = bus_data;
                    fph = 0;
                end
                4: begin
                    if (fcnt == 0) begin
                        fol_drv  = 1'b1;
                        fol_data = fol_mem[{fmid, flo}];
                        fph      = 5;
                    end else begin
                        fcnt--;
                    end
                end
                default: begin
                    fol_drv = 1'b0;
                    fph     = 0;
                end
            endcase
        end
    end

    // Starts and ends at a falling edge; waits for req_ready within a cycle budget.
    task automatic push(input bit w, input logic [23:0] a, input logic [7:0] d);
        int   n;
        req_t r;
        n = 0;
        rq.req_valid = 1'b1;
        rq.req_write = w;
        rq.req_addr  = a;
        rq.req_wdata = d;
        while (rq.req_ready !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check_val("push_accept", rq.req_ready, 1);
        if (rq.req_ready === 1'b1) begin
            r.w = w; r.a = a; r.d = d;
            iss_q.push_back(r);
            exp_q.push_back(model(w, a, d));
            @(posedge clock);
            #1 push_cyc = cyc;
            @(negedge clock);
        end
        rq.req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rq.busy !== 1'b0) && n < 600) begin
            @(negedge clock);
            #1;
            n++;
        end
        check_val(tag, exp_q.size(), 0);
    endtask

    initial begin
        int pc;
        rq.req_valid = 1'b0;
        rq.req_write = 1'b0;
        rq.req_addr  = 24'h0;
        rq.req_wdata = 8'h0;
        for (int i = 0; i < 65536; i++) begin
            ref_mem[i] = 8'(i * 7 + 3);
            fol_mem[i] = ref_mem[i];
        end

        repeat (3) @(negedge clock);
        check_val("rst_ready", rq.req_ready, 1);
        check_val("rst_busy", rq.busy, 0);
        check_val("rst_rsp_valid", rq.rsp_valid, 0);
        check_val("rst_rsp_write", rq.rsp_write, 0);
        check_val("rst_rsp_data", rq.rsp_data, 0);
        check_val("rst_rsp_err", rq.rsp_err, 0);
        check_val("rst_bus_start", bus_start, 0);
        check_val("rst_bus_read", bus_read, 0);
        resetN = 1'b1;
        repeat (2) @(negedge clock);

        // Single write then read-back with fixed latency checks.
        rsp_cyc_q.delete();
        push(1'b1, 24'h000406, 8'hDC);
        pc = push_cyc;
        wait_drain("drain_write");
        check_val("lat_write", rsp_cyc_q.size() > 0 ? rsp_cyc_q[0] - pc : -1, 5);

        fol_fixed_d = 3;
        rsp_cyc_q.delete();
        push(1'b0, 24'h000406, 8'h00);
        pc = push_cyc;
        wait_drain("drain_read");
        check_val("lat_read", rsp_cyc_q.size() > 0 ? rsp_cyc_q[0] - pc : -1, 8);

        // Valid on the last permitted wait cycle still wins.
        fol_fixed_d = TIMEOUT - 1;
        rsp_cyc_q.delete();
        push(1'b0, 24'h000406, 8'h00);
        pc = push_cyc;
        wait_drain("drain_read_edge");
        check_val("lat_read_edge", rsp_cyc_q.size() > 0 ? rsp_cyc_q[0] - pc : -1, 4 + TIMEOUT);
        fol_fixed_d = -1;

        // Timeout on an absent follower, then a queued write proceeds.
        rsp_cyc_q.delete();
        push(1'b0, 24'h050000, 8'h00);
        pc = push_cyc;
        push(1'b1, 24'h000407, 8'hA5);
        wait_drain("drain_timeout");
        check_val("n_rsp_timeout", rsp_cyc_q.size(), 2);
        if (rsp_cyc_q.size() == 2) begin
            check_val("lat_timeout", rsp_cyc_q[0] - pc, 4 + TIMEOUT);
            check_val("lat_after_timeout", rsp_cyc_q[1] - pc, 4 + TIMEOUT + 5);
        end

        // Fill the FIFO while the head read is stalled.
        push(1'b0, 24'h050000, 8'h00);
        repeat (3) @(negedge clock);
        for (int i = 0; i < DEPTH; i++) begin
            check_val("ready_before_full", rq.req_ready, 1);
            push(1'b1, 24'h20 + 24'(i), 8'h30 + 8'(i));
        end
        check_val("ready_full", rq.req_ready, 0);
        check_val("busy_full", rq.busy, 1);
        push(1'b0, 24'h000021, 8'h00);
        wait_drain("drain_full");

        // Write, write, read, read in order.
        push(1'b1, 24'h000010, 8'h11);
        push(1'b1, 24'h000011, 8'h22);
        push(1'b0, 24'h000010, 8'h00);
        push(1'b0, 24'h000011, 8'h00);
        wait_drain("drain_wwrr");

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            bit          w;
            logic [23:0] a;
            w = 1'($urandom_range(0, 1));
            a = {(($urandom_range(0, 5) == 0) ? 8'h05 : 8'h00), 8'h01, 8'($urandom_range(0, 15))};
            push(w, a, 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        wait_drain("drain_random");

        // Reset while a read waits with two more queued.
        push(1'b0, 24'h050000, 8'h00);
        push(1'b0, 24'h000010, 8'h00);
        push(1'b0, 24'h000011, 8'h00);
        repeat (4) @(negedge clock);
        check_val("busy_pre_reset", rq.busy, 1);
        #2 resetN = 1'b0;
        #1;
        check_val("mid_rst_bus_start", bus_start, 0);
        check_val("mid_rst_bus_read", bus_read, 0);
        check_val("mid_rst_busy", rq.busy, 0);
        check_val("mid_rst_ready", rq.req_ready, 1);
        check_val("mid_rst_rsp_valid", rq.rsp_valid, 0);
        exp_q.delete();
        iss_q.delete();
        repeat (3) @(negedge clock);
        check_val("in_rst_rsp_valid", rq.rsp_valid, 0);
        resetN = 1'b1;
        repeat (2) @(negedge clock);
        check_val("post_rst_rsp_valid", rq.rsp_valid, 0);
        push(1'b1, 24'h000030, 8'h77);
        push(1'b0, 24'h000030, 8'h00);
        wait_drain("drain_post_reset");

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errs, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
